div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 135 +++++++++++++
 tb/tb_div_unit.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit: one radix-2 restoring step per cycle, 33-cycle latency.
// Optional macro DIV_ZERO_FAST_EN completes a divide by zero in one cycle.
module div_unit (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start_i,
   input  logic        signed_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        annul_i,
   input  logic        hold_i,
   output logic        stall_div_o,
   output logic        ready_o,
   output logic [63:0] result_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic        block_q, block_d;

   logic        accept;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] rem_shift;
   logic [32:0] rem_sub;
   logic [31:0] quo_out;
   logic [31:0] rem_out;

   // block_q remembers that start_i has not yet dropped since the last completion
   always_comb begin
      a_mag     = (signed_i && a_i[31]) ? (~a_i + 32'd1) : a_i;
      b_mag     = (signed_i && b_i[31]) ? (~b_i + 32'd1) : b_i;
      accept    = (state_q == IDLE) && start_i && !annul_i && !block_q;
      rem_shift = {rem_q, quo_q[31]};
      rem_sub   = rem_shift - {1'b0, dvs_q};
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      block_d   = block_q;
      case (state_q)
         IDLE: begin
            block_d = block_q & start_i;
            if (accept) begin
               state_d   = BUSY;
               cnt_d     = 5'd0;
               rem_d     = 32'd0;
               quo_d     = a_mag;
               dvs_d     = b_mag;
               neg_quo_d = signed_i & (a_i[31] ^ b_i[31]);
               neg_rem_d = signed_i & a_i[31];
`ifdef DIV_ZERO_FAST_EN
               if (b_i == 32'd0) begin
                  state_d   = DONE;
                  rem_d     = a_i;
                  quo_d     = 32'hFFFF_FFFF;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
               end
`endif
            end
         end
         BUSY: begin
            // A clear borrow bit means the shifted remainder covered the divisor
            rem_d = rem_sub[32] ? rem_shift[31:0] : rem_sub[31:0];
            quo_d = {quo_q[30:0], ~rem_sub[32]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = DONE;
            end
         end
         DONE: begin
            block_d = 1'b1;
            if (!hold_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (annul_i) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         cnt_q     <= 5'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         dvs_q     <= 32'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         block_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         block_q   <= block_d;
      end
   end

   // Stall is gated by reset so a held start_i cannot stall the pipeline during reset
   always_comb begin
      quo_out     = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
      rem_out     = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
      stall_div_o = resetn && !annul_i && (accept || (state_q == BUSY));
      ready_o     = (state_q == DONE);
      result_o    = (state_q == DONE) ? {rem_out, quo_out} : 64'd0;
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected {remainder, quotient} values,
// latency/stall checks, annul, hold, restart inhibit, mid-operation reset and divide by zero.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start_i;
   logic        signed_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        annul_i;
   logic        hold_i;
   logic        stall_div_o;
   logic        ready_o;
   logic [63:0] result_o;

   int checks = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   div_unit dut (
      .clk        (clk),
      .resetn     (resetn),
      .start_i    (start_i),
      .signed_i   (signed_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .annul_i    (annul_i),
      .hold_i     (hold_i),
      .stall_div_o(stall_div_o),
      .ready_o    (ready_o),
      .result_o   (result_o)
   );

   always #5 clk = ~clk;

   // Reference division on magnitudes with sign fixup applied afterwards
   function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      logic [31:0] ma;
      logic [31:0] mb;
      logic [31:0] q;
      logic [31:0] r;
      ma = (sgn && a[31]) ? (32'd0 - a) : a;
      mb = (sgn && b[31]) ? (32'd0 - b) : b;
      q  = ma / mb;
      r  = ma % mb;
      if (sgn && (a[31] ^ b[31])) q = 32'd0 - q;
      if (sgn && a[31]) r = 32'd0 - r;
      return {r, q};
   endfunction

   // Waits for ready_o, returning how many cycles after the start cycle it appeared
   task automatic wait_ready(output int n);
      n = 0;
      while (ready_o !== 1'b1 && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      start_i  = 1'b1;
      signed_i = 1'b0;
      a_i      = 32'd5;
      b_i      = 32'd1;
      annul_i  = 1'b0;
      hold_i   = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (stall_div_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got stall=%b ready=%b result=%h, need 0/0/0", stall_div_o, ready_o, result_o);
      end
      @(negedge clk);
      start_i = 1'b0;
      resetn  = 1'b1;
      #1;
      checks++;
      if (stall_div_o !== 1'b0 || ready_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_release_idle: got stall=%b ready=%b, need 0/0", stall_div_o, ready_o);
      end
   endtask

   task automatic test_divu_latency();
      logic [63:0] expv;
      logic        bad;
      exp_q.push_back(64'h00000002_0000000E);
      @(negedge clk);
      start_i  = 1'b1;
      signed_i = 1'b0;
      a_i      = 32'd100;
      b_i      = 32'd7;
      #1;
      bad = 1'b0;
      for (int c = 0; c <= 32; c++) begin
         if (c > 0) begin
            @(negedge clk);
            #1;
         end
         checks++;
         if (stall_div_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 64'd0) begin
            failures++;
            bad = 1'b1;
            $display("[TB] FAIL divu_busy_cycle%0d: got stall=%b ready=%b result=%h, need 1/0/0", c, stall_div_o, ready_o, result_o);
         end
      end
      @(negedge clk);
      #1;
      expv = exp_q.pop_front();
      checks++;
      if (ready_o !== 1'b1 || stall_div_o !== 1'b0 || result_o !== expv) begin
         failures++;
         $display("[TB] FAIL divu_done_cycle33: got ready=%b stall=%b result=%h, need 1/0/%h", ready_o, stall_div_o, result_o, expv);
      end
      @(negedge clk);
      start_i = 1'b0;
      #1;
      checks++;
      if (ready_o !== 1'b0 || stall_div_o !== 1'b0 || result_o !== 64'd0) begin
         failures++;
         $display("[TB] FAIL divu_back_idle: got ready=%b stall=%b result=%h, need 0/0/0", ready_o, stall_div_o, result_o);
      end
      if (bad) $display("[TB] divu latency sequence had errors");
   endtask

   task automatic test_arith();
      logic [31:0] ta[10];
      logic [31:0] tb[10];
      logic        ts[10];
      logic [63:0] expv;
      int          n;
      ta = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100,      32'hFFFF_FFFF, 32'h8000_0000,
             32'd5,         32'd1,         32'h8000_0000, 32'hFFFF_FFF9, 32'd0};
      tb = '{32'd2,         32'hFFFF_FFFF, 32'd7,        32'd1,         32'd2,
             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd9};
      ts = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i < 10) begin
            a_i      = ta[i];
            b_i      = tb[i];
            signed_i = ts[i];
         end else begin
            a_i      = $urandom;
            b_i      = $urandom;
            if (b_i == 32'd0) b_i = 32'd3;
            signed_i = $urandom_range(0, 1);
         end
         exp_q.push_back(model_div(a_i, b_i, signed_i));
         start_i = 1'b1;
         #1;
         wait_ready(n);
         expv = exp_q.pop_front();
         checks++;
         if (n != 33 || result_o !== expv) begin
            failures++;
            $display("[TB] FAIL arith_%0d a=%h b=%h s=%b: got latency=%0d result=%h, need 33/%h", i, a_i, b_i, signed_i, n, result_o, expv);
         end
         @(negedge clk);
         start_i = 1'b0;
      end
      checks++;
      if (model_div(32'hFFFF_FFF9, 32'd2, 1'b1) !== 64'hFFFFFFFF_FFFFFFFD) begin
         failures++;
         $display("[TB] FAIL model_neg7_div2: got %h, need ffffffff_fffffffd", model_div(32'hFFFF_FFF9, 32'd2, 1'b1));
      end
   endtask

   task automatic test_annul();
      logic [63:0] expv;
      int          n;
      logic        seen;
      @(negedge clk);
      start_i  = 1'b1;
      signed_i = 1'b0;
      a_i      = 32'd50;
      b_i      = 32'd3;
      seen     = 1'b0;
      repeat (9) begin
         @(negedge clk);
         #1;
         if (ready_o === 1'b1) seen = 1'b1;
      end
      @(negedge clk);
      annul_i = 1'b1;
      #1;
      checks++;
      if (stall_div_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL annul_stall_drop: got stall=%b, need 0", stall_div_o);
      end
      @(negedge clk);
      annul_i = 1'b0;
      start_i = 1'b0;
      #1;
      if (ready_o === 1'b1 || stall_div_o === 1'b1) seen = 1'b1;
      @(negedge clk);
      #1;
      if (ready_o === 1'b1 || stall_div_o === 1'b1) seen = 1'b1;
      checks++;
      if (seen) begin
         failures++;
         $display("[TB] FAIL annul_idle: got activity after annul=1, need 0");
      end
      @(negedge clk);
      start_i = 1'b1;
      a_i     = 32'd1000;
      b_i     = 32'd10;
      exp_q.push_back(model_div(a_i, b_i, signed_i));
      #1;
      wait_ready(n);
      expv = exp_q.pop_front();
      checks++;
      if (n != 33 || result_o !== expv) begin
         failures++;
         $display("[TB] FAIL annul_restart: got latency=%0d result=%h, need 33/%h", n, result_o, expv);
      end
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      start_i = 1'b1;
      annul_i = 1'b1;
      a_i     = 32'd77;
      b_i     = 32'd5;
      exp_q.push_back(model_div(a_i, b_i, signed_i));
      #1;
      checks++;
      if (stall_div_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL annul_with_start_stall: got stall=%b, need 0", stall_div_o);
      end
      @(negedge clk);
      annul_i = 1'b0;
      #1;
      wait_ready(n);
      expv = exp_q.pop_front();
      checks++;
      if (n != 33 || result_o !== expv) begin
         failures++;
         $display("[TB] FAIL annul_with_start_ignored: got latency=%0d result=%h, need 33/%h", n, result_o, expv);
      end
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic test_hold();
      logic [63:0] expv;
      logic [63:0] held;
      int          n;
      @(negedge clk);
      start_i  = 1'b1;
      signed_i = 1'b1;
      a_i      = 32'hFFFF_FF00;
      b_i      = 32'd7;
      exp_q.push_back(model_div(a_i, b_i, signed_i));
      #1;
      wait_ready(n);
      hold_i = 1'b1;
      held   = result_o;
      expv   = exp_q.pop_front();
      checks++;
      if (n != 33 || held !== expv) begin
         failures++;
         $display("[TB] FAIL hold_first: got latency=%0d result=%h, need 33/%h", n, held, expv);
      end
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 3) hold_i = 1'b0;
         #1;
         checks++;
         if (ready_o !== 1'b1 || result_o !== expv || stall_div_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_cycle%0d: got ready=%b stall=%b result=%h, need 1/0/%h", 33 + k, ready_o, stall_div_o, result_o, expv);
         end
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (ready_o !== 1'b0 || stall_div_o !== 1'b0 || result_o !== 64'd0) begin
            failures++;
            $display("[TB] FAIL hold_no_restart_cycle%0d: got ready=%b stall=%b result=%h, need 0/0/0", 37 + k, ready_o, stall_div_o, result_o);
         end
      end
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [63:0] expv;
      int          n;
      for (int op = 0; op < 2; op++) begin
         @(negedge clk);
         start_i  = 1'b1;
         signed_i = 1'b0;
         a_i      = 32'd12345 + op;
         b_i      = 32'd11 + op;
         exp_q.push_back(model_div(a_i, b_i, signed_i));
         #1;
         checks++;
         if (stall_div_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_start%0d_stall: got %b, need 1", op, stall_div_o);
         end
         wait_ready(n);
         expv = exp_q.pop_front();
         checks++;
         if (n != 33 || result_o !== expv) begin
            failures++;
            $display("[TB] FAIL b2b_op%0d: got latency=%0d result=%h, need 33/%h", op, n, result_o, expv);
         end
         @(negedge clk);
         start_i = 1'b0;
         #1;
         checks++;
         if (stall_div_o !== 1'b0 || ready_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_gap%0d: got stall=%b ready=%b, need 0/0", op, stall_div_o, ready_o);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] expv;
      int          n;
      @(negedge clk);
      start_i  = 1'b1;
      signed_i = 1'b0;
      a_i      = 32'd999;
      b_i      = 32'd4;
      repeat (20) @(negedge clk);
      resetn = 1'b0;
      #1;
      checks++;
      if (stall_div_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
         failures++;
         $display("[TB] FAIL reset_mid_outputs: got stall=%b ready=%b result=%h, need 0/0/0", stall_div_o, ready_o, result_o);
      end
      @(negedge clk);
      resetn = 1'b1;
      a_i    = 32'd9;
      b_i    = 32'd3;
      exp_q.push_back(64'h00000000_00000003);
      #1;
      checks++;
      if (stall_div_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_mid_first_start: got stall=%b, need 1", stall_div_o);
      end
      wait_ready(n);
      expv = exp_q.pop_front();
      checks++;
      if (n != 33 || result_o !== expv) begin
         failures++;
         $display("[TB] FAIL reset_mid_divu_9_3: got latency=%0d result=%h, need 33/%h", n, result_o, expv);
      end
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic test_div_zero();
      int n;
      @(negedge clk);
      start_i  = 1'b1;
      signed_i = 1'b0;
      a_i      = 32'h0000_1234;
      b_i      = 32'd0;
      #1;
      checks++;
      if (stall_div_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL divzero_cycle0_stall: got %b, need 1", stall_div_o);
      end
      wait_ready(n);
`ifdef DIV_ZERO_FAST_EN
      checks++;
      if (n != 1 || result_o !== 64'h00001234_FFFFFFFF || stall_div_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL divzero_fast: got latency=%0d stall=%b result=%h, need 1/0/00001234ffffffff", n, stall_div_o, result_o);
      end
`else
      checks++;
      if (n != 33) begin
         failures++;
         $display("[TB] FAIL divzero_latency: got %0d, need 33", n);
      end
`endif
      @(negedge clk);
      start_i = 1'b0;
      #1;
      checks++;
      if (ready_o !== 1'b0 || stall_div_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL divzero_idle: got ready=%b stall=%b, need 0/0", ready_o, stall_div_o);
      end
   endtask

   initial begin
      test_reset();
      test_divu_latency();
      test_arith();
      test_annul();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      test_div_zero();
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries left, need 0", exp_q.size());
      end
      checks++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no finish, need finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
